// File: rtl/ext_pipe.sv
// ext_pipe: registered sign/zero extension with post-shift and overflow flag,
// behind a valid/ready handshake with a two-entry skid buffer.
module ext_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [1:0]           in_wsel,
  input  logic                 in_sgn,
  input  logic [1:0]           in_shl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf
);
  logic [OUT_WIDTH-1:0] e8, e16, ef, e, r, rl;
  logic signed [OUT_WIDTH-1:0] ra;
  logic ovf, acc;
  logic m_v_q, m_v_d, s_v_q, s_v_d, m_ovf_q, m_ovf_d, s_ovf_q, s_ovf_d;
  logic [OUT_WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;

  assign e8  = {{(OUT_WIDTH-8){in_sgn & in_data[7]}}, in_data[7:0]};
  assign e16 = {{(OUT_WIDTH-16){in_sgn & in_data[15]}}, in_data[15:0]};
  generate
    if (IN_WIDTH == OUT_WIDTH) begin : g_eq
      assign ef = in_data;
    end else begin : g_ext
      assign ef = {{(OUT_WIDTH-IN_WIDTH){in_sgn & in_data[IN_WIDTH-1]}}, in_data};
    end
  endgenerate
  assign e  = in_wsel == 2'd0 ? e8 : in_wsel == 2'd1 ? e16 : ef;
  assign r  = e << in_shl;
  // Shift back and compare: any mismatch means significant bits fell off the top
  assign ra  = $signed(r) >>> in_shl;
  assign rl  = r >> in_shl;
  assign ovf = (in_sgn ? ra : rl) != e;
  assign in_ready = ~s_v_q;
  assign acc = in_valid & in_ready & ~flush;

  always_comb begin
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_data_d = m_data_q;
    m_ovf_d  = m_ovf_q;
    s_data_d = s_data_q;
    s_ovf_d  = s_ovf_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (s_v_q) begin
      if (out_ready) begin
        m_data_d = s_data_q;
        m_ovf_d  = s_ovf_q;
        s_v_d    = 1'b0;
      end
    end else if (!m_v_q || out_ready) begin
      m_v_d = acc;
      if (acc) begin
        m_data_d = r;
        m_ovf_d  = ovf;
      end
    end else if (acc) begin
      s_v_d    = 1'b1;
      s_data_d = r;
      s_ovf_d  = ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_data_q <= '0;
      m_ovf_q  <= 1'b0;
      s_data_q <= '0;
      s_ovf_q  <= 1'b0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_data_q <= m_data_d;
      m_ovf_q  <= m_ovf_d;
      s_data_q <= s_data_d;
      s_ovf_q  <= s_ovf_d;
    end
  end

  assign out_valid = m_v_q;
  assign out_data  = m_data_q;
  assign out_ovf   = m_ovf_q;
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: scenario tasks plus randomized traffic checked against a
// FIFO-level reference model of the extension stage.
module tb_ext_pipe;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_sgn = 0, out_ready = 0;
  logic in_ready, out_valid, out_ovf;
  logic [31:0] in_data = 0, out_data;
  logic [1:0] in_wsel = 0, in_shl = 0;
  int tests = 0, fails = 0;
  bit acc_m;

  typedef struct { logic [31:0] d; logic o; } item_t;
  item_t q[$];

  ext_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_wsel(in_wsel), .in_sgn(in_sgn), .in_shl(in_shl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: extend to a 64-bit integer, scale, then test range
  function automatic item_t ref_ext(input logic [31:0] d, input logic [1:0] w, input logic s, input logic [1:0] sh);
    item_t it;
    longint f, e, p, lim31, lim32;
    int bw;
    bw = w == 0 ? 8 : w == 1 ? 16 : 32;
    lim31 = longint'(1) << 31;
    lim32 = longint'(1) << 32;
    f = d;
    f = f & ((longint'(1) << bw) - 1);
    e = (s && ((f >> (bw - 1)) & 1) == 1) ? f - (longint'(1) << bw) : f;
    p = e * (longint'(1) << sh);
    it.d = p[31:0];
    it.o = s ? (p < -lim31 || p >= lim31) : (p >= lim32);
    return it;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] d, input logic [1:0] w, input logic s, input logic [1:0] sh);
    in_valid = v; in_data = d; in_wsel = w; in_sgn = s; in_shl = sh;
  endtask

  task automatic tick(output bit acc);
    item_t it;
    bit pop;
    it = ref_ext(in_data, in_wsel, in_sgn, in_shl);
    acc = rst_n && !flush && in_valid && q.size() < 2;
    pop = q.size() > 0 && out_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(it);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_extend();
    logic [31:0] w_d [3] = '{32'hFFFF8080, 32'h00008080, 32'hFFFFFF80};
    logic [1:0]  ws  [3] = '{2'd1, 2'd1, 2'd0};
    logic        sg  [3] = '{1'b1, 1'b0, 1'b1};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h0000_8080, ws[i], sg[i], 0);
      tick(acc_m);
      tests++;
      if (out_valid !== 1'b1 || out_data !== w_d[i] || out_ovf !== 1'b0) begin
        fails++; $display("FAIL extend_%0d: valid=%b data=%h ovf=%b want 1 %h 0", i, out_valid, out_data, out_ovf, w_d[i]);
      end
    end
    set_in(0, 0, 0, 0, 0);
    tick(acc_m);
  endtask

  task automatic test_shift();
    logic [31:0] d   [4] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0040, 32'h4000_0000};
    logic        sg  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  ws  [4] = '{2'd2, 2'd2, 2'd0, 2'd2};
    logic [1:0]  sh  [4] = '{2'd2, 2'd3, 2'd1, 2'd1};
    logic [31:0] w_d [4] = '{32'h0, 32'hFFFF_FFF8, 32'h0000_0080, 32'h8000_0000};
    logic        w_o [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_in(1, d[i], ws[i], sg[i], sh[i]);
      tick(acc_m);
      tests++;
      if (out_valid !== 1'b1 || out_data !== w_d[i] || out_ovf !== w_o[i]) begin
        fails++; $display("FAIL shift_%0d: valid=%b data=%h ovf=%b want 1 %h %b", i, out_valid, out_data, out_ovf, w_d[i], w_o[i]);
      end
    end
    set_in(0, 0, 0, 0, 0);
    tick(acc_m);
  endtask

  task automatic test_backpressure();
    int v = 1, nacc = 0, ex = 1;
    bit a;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, v, 2, 0, 0);
      a = in_ready;
      tick(acc_m);
      if (a) begin v++; nacc++; end
      if (i >= 1) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
      end
    end
    tests++; if (nacc != 2) begin fails++; $display("FAIL bp_accepts: got %0d want 2", nacc); end
    tests++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin fails++; $display("FAIL bp_hold: valid=%b data=%h want 1 1", out_valid, out_data); end
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      set_in(1, v, 2, 0, 0);
      a = in_ready;
      tick(acc_m);
      if (a) v++;
      ex++;
      tests++;
      if (out_valid !== 1'b1 || out_data !== ex) begin fails++; $display("FAIL bp_order_%0d: valid=%b data=%h want 1 %h", i, out_valid, out_data, ex); end
    end
    set_in(0, 0, 0, 0, 0);
    tick(acc_m);
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_in(1, 100 + i, 2, 0, 0);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); end
      tick(acc_m);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 100 + i) begin fails++; $display("FAIL b2b_out_%0d: valid=%b data=%h want 1 %h", i, out_valid, out_data, 100 + i); end
    end
    set_in(0, 0, 0, 0, 0);
    tick(acc_m);
  endtask

  task automatic test_flush();
    out_ready = 0;
    set_in(1, 32'hA1, 2, 0, 0); tick(acc_m);
    set_in(1, 32'hA2, 2, 0, 0); tick(acc_m);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_full: ready=%b want 0", in_ready); end
    flush = 1;
    set_in(1, 32'hDEAD, 2, 0, 0); tick(acc_m);
    flush = 0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_state: valid=%b ready=%b want 0 1", out_valid, in_ready); end
    set_in(0, 0, 0, 0, 0);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick(acc_m);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_gone_%0d: valid=%b data=%h want 0", i, out_valid, out_data); end
    end
    set_in(1, 32'h55, 2, 0, 0); tick(acc_m);
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin fails++; $display("FAIL flush_resume: valid=%b data=%h want 1 55", out_valid, out_data); end
    set_in(0, 0, 0, 0, 0); tick(acc_m);
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    set_in(1, 32'hB1, 2, 0, 0); tick(acc_m);
    set_in(1, 32'hB2, 2, 0, 0); tick(acc_m);
    set_in(0, 0, 0, 0, 0);
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL arst_full: ready=%b valid=%b want 0 1", in_ready, out_valid); end
    #2 rst_n = 0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL arst_now: valid=%b ready=%b want 0 1", out_valid, in_ready); end
    q.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    set_in(1, 32'h77, 2, 0, 0); tick(acc_m);
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin fails++; $display("FAIL arst_resume: valid=%b data=%h want 1 77", out_valid, out_data); end
    set_in(0, 0, 0, 0, 0); tick(acc_m);
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 31) == 0;
      d = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 255) << $urandom_range(0, 30);
      set_in($urandom_range(0, 3) != 0, d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rnd_ready_%0d: got %b want %b", i, in_ready, q.size() < 2); end
      tick(acc_m);
      tests++;
      if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL rnd_valid_%0d: got %b want %b", i, out_valid, q.size() > 0); end
      else if (q.size() > 0 && (out_data !== q[0].d || out_ovf !== q[0].o)) begin
        fails++; $display("FAIL rnd_data_%0d: data=%h ovf=%b want %h %b", i, out_data, out_ovf, q[0].d, q[0].o);
      end
    end
    flush = 0;
    set_in(0, 0, 0, 0, 0);
    out_ready = 1;
    repeat (3) tick(acc_m);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_extend();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
